// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the instruction encoder: opcode/funct3 constants,
// FSM state and instruction-format enums, and immediate range helpers.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_HALT} state_t;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_t;

  function automatic fmt_t fmt_of(input logic [6:0] op);
    fmt_t f;
    case (op)
      OP_RTYPE:                                    f = FMT_R;
      OP_LOAD, OP_ITYPE, OP_JALR, OP_FENCE, OP_SYSTEM: f = FMT_I;
      OP_STORE:                                    f = FMT_S;
      OP_BRANCH:                                   f = FMT_B;
      OP_LUI, OP_AUIPC:                            f = FMT_U;
      OP_JAL:                                      f = FMT_J;
      default:                                     f = FMT_BAD;
    endcase
    return f;
  endfunction

  // True when imm is the sign extension of its low n bits.
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned n);
    logic [31:0] hi;
    hi = $signed(imm) >>> (n - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/rv32i_inst_pack.sv
// Combinational RV32I field packer: builds the instruction word for the opcode's
// format and flags tuples whose immediate cannot be represented.
module rv32i_inst_pack
  import rv32i_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err
);

  fmt_t w_fmt;
  logic w_shift;

  assign w_fmt   = fmt_of(i_opcode);
  assign w_shift = (i_opcode == OP_ITYPE) && (i_funct3 == F3_SLL || i_funct3 == F3_SRL_SRA);

  always_comb begin
    o_word = '0;
    o_err  = 1'b0;
    case (w_fmt)
      FMT_R: o_word = {i_funct7, i_rs2_addr, i_rs1_addr, i_funct3, i_rd_addr, i_opcode};
      FMT_I: begin
        if (w_shift) begin
          o_word = {i_funct7, i_imm[4:0], i_rs1_addr, i_funct3, i_rd_addr, i_opcode};
          o_err  = |i_imm[31:5];
        end else begin
          o_word = {i_imm[11:0], i_rs1_addr, i_funct3, i_rd_addr, i_opcode};
          o_err  = !fits_signed(i_imm, 12);
        end
      end
      FMT_S: begin
        o_word = {i_imm[11:5], i_rs2_addr, i_rs1_addr, i_funct3, i_imm[4:0], i_opcode};
        o_err  = !fits_signed(i_imm, 12);
      end
      FMT_B: begin
        o_word = {i_imm[12], i_imm[10:5], i_rs2_addr, i_rs1_addr, i_funct3,
                  i_imm[4:1], i_imm[11], i_opcode};
        o_err  = !fits_signed(i_imm, 13) || i_imm[0];
      end
      FMT_U: begin
        o_word = {i_imm[31:12], i_rd_addr, i_opcode};
        o_err  = |i_imm[11:0];
      end
      FMT_J: begin
        o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd_addr, i_opcode};
        o_err  = !fits_signed(i_imm, 21) || i_imm[0];
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_encoder.sv
// Streaming RV32I encoder: accepts field tuples, packs them into words and writes
// them to consecutive word addresses through a one-entry output register.
module rv32i_encoder
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  input  logic [4:0]       i_rd_addr,
  input  logic [31:0]      i_imm,
  input  logic             i_load_addr,
  input  logic [31:0]      i_start_addr,
  input  logic             i_clear,
  output logic             o_wr_en,
  output logic [31:0]      o_wr_addr,
  output logic [31:0]      o_wr_data,
  input  logic             i_wr_ready,
  output logic             o_err,
  output logic [6:0]       o_err_opcode,
  output logic [CNT_W-1:0] o_count,
  output state_t           o_state
);

  // Handshakes: a tuple transfers on a rising edge with i_valid && o_ready;
  // a write completes on a rising edge with o_wr_en && i_wr_ready. The output
  // word, address and o_wr_en stay unchanged until that completion.

  state_t           r_state;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic [31:0]      r_ptr;
  logic             r_err;
  logic [6:0]       r_err_opcode;
  logic [CNT_W-1:0] r_count;

  logic [31:0] w_word;
  logic        w_pack_err;
  logic        w_ready;
  logic        w_accept;
  logic        w_wr_done;

  rv32i_inst_pack u_pack (
    .i_opcode   (i_opcode),
    .i_funct3   (i_funct3),
    .i_funct7   (i_funct7),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .i_rd_addr  (i_rd_addr),
    .i_imm      (i_imm),
    .o_word     (w_word),
    .o_err      (w_pack_err)
  );

  assign w_ready   = (r_state == ST_STREAM) && !i_load_addr && (!r_wr_en || i_wr_ready);
  assign w_accept  = i_valid && w_ready;
  assign w_wr_done = r_wr_en && i_wr_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_ptr        <= '0;
      r_err        <= 1'b0;
      r_err_opcode <= '0;
      r_count      <= '0;
    end else begin
      if (w_wr_done) begin
        r_wr_en <= 1'b0;
        if (r_count != '1) r_count <= r_count + 1'b1;
      end
      if (i_clear) begin
        r_err        <= 1'b0;
        r_err_opcode <= '0;
      end
      // Clear wins over load in HALT; load never touches the pending word.
      case (r_state)
        ST_IDLE: if (i_load_addr) begin
          r_ptr   <= i_start_addr;
          r_state <= ST_STREAM;
        end
        ST_STREAM: if (i_load_addr) r_ptr <= i_start_addr;
        ST_HALT:   if (i_clear) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
      if (w_accept) begin
        if (w_pack_err) begin
          r_err        <= 1'b1;
          r_err_opcode <= i_opcode;
          r_state      <= ST_HALT;
        end else begin
          r_wr_en   <= 1'b1;
          r_wr_data <= w_word;
          r_wr_addr <= r_ptr;
          r_ptr     <= r_ptr + 32'd4;
        end
      end
    end
  end

  assign o_ready      = w_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_err        = r_err;
  assign o_err_opcode = r_err_opcode;
  assign o_count      = r_count;
  assign o_state      = r_state;

endmodule

// File: doc/rv32i_encoder.md
RV32I_ENCODER -- requirements
Module: rv32i_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the written-word counter.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports i_valid input 1 and o_ready output 1: the field-tuple handshake; a transfer occurs when both are 1 on a clock edge.
REQ-005 SHALL have inputs i_opcode 7, i_funct3 3, i_funct7 7, i_rs1_addr 5, i_rs2_addr 5, i_rd_addr 5 and i_imm 32 (the fully sign-extended immediate, as the decoder produces it).
REQ-006 SHALL have inputs i_load_addr 1 (load-address strobe) and i_start_addr 32 (new write address).
REQ-007 SHALL have input i_clear 1, which leaves the HALT state.
REQ-008 SHALL have outputs o_wr_en 1, o_wr_addr 32 and o_wr_data 32, plus input i_wr_ready 1: the memory-write handshake; a write completes when o_wr_en and i_wr_ready are both 1.
REQ-009 SHALL have outputs o_err 1 (sticky error), o_err_opcode 7 (opcode of the offending tuple) and o_count CNT_W (number of completed writes).

Function
REQ-010 FSM states SHALL be IDLE, STREAM and HALT; IDLE→STREAM on i_load_addr; STREAM→HALT on encode error; HALT→IDLE on i_clear.
REQ-011 o_ready SHALL be 1 only in STREAM, with i_load_addr=0, and with the output register empty or completing this cycle (o_wr_en=0 or i_wr_ready=1).
REQ-012 An accepted tuple SHALL appear on o_wr_en/o_wr_data/o_wr_addr on the next cycle (latency 1) and be held stable until i_wr_ready=1.
REQ-013 Encoding SHALL place opcode in [6:0], rd in [11:7], funct3 in [14:12], rs1 in [19:15], rs2 in [24:20] and funct7 in [31:25] for R-type.
REQ-014 Encoding SHALL use the I layout for LOAD/ITYPE/JALR/FENCE/SYSTEM, with imm[11:0] in [31:20].
REQ-015 For ITYPE with funct3 001/101, encoding SHALL use {i_funct7, imm[4:0]} in [31:20].
REQ-016 Encoding SHALL use the S, B, U and J layouts per the RV32I base spec for STORE, BRANCH, LUI/AUIPC and JAL respectively.
REQ-017 An encode error SHALL occur for:
  - an unknown opcode;
  - I/S immediate not 12-bit sign-extended;
  - shift shamt with imm[31:5]≠0;
  - B immediate not 13-bit signed, or imm[0]=1;
  - J immediate not 21-bit signed, or imm[0]=1;
  - U immediate with imm[11:0]≠0.
REQ-018 On error: the tuple SHALL NOT be written; o_err=1 and o_err_opcode captured the next cycle; any word already pending SHALL still complete.
REQ-019 o_wr_addr SHALL be the write pointer captured at accept; the pointer SHALL increment by 4 per accepted tuple and wrap modulo 2^32.
REQ-020 i_load_addr SHALL load i_start_addr into the pointer in IDLE or STREAM, SHALL block acceptance that cycle, and SHALL NOT alter a pending word's address.
REQ-021 o_count SHALL increment per completed write and saturate at 2^CNT_W−1; i_load_addr SHALL NOT clear it.
REQ-022 i_clear SHALL zero o_err and o_err_opcode; i_clear outside HALT SHALL only clear those flags.
REQ-023 i_load_addr and i_clear in HALT in the same cycle: i_clear SHALL win (→IDLE), and the load SHALL be ignored.

Reset
REQ-024 i_rst SHALL asynchronously force:
  - state IDLE;
  - o_ready, o_wr_en and o_err to 0;
  - o_wr_addr, o_wr_data, o_err_opcode, o_count and the pointer to 0.
REQ-025 Reset mid-write SHALL drop the pending word, and no write SHALL complete after reset assertion.

Structure
REQ-026 Opcode/funct3 constants SHALL come from the shared rv32i decoder header; the FSM state typedef and format enum SHALL go in a shared package rv32i_pkg.
REQ-027 Pure-combinational field packing and range checking SHALL be one sub-module, rv32i_inst_pack (outputs: word, err); handshake, FSM and counters SHALL stay in rv32i_encoder.

Verification
REQ-028 Load 0x100; ADD rd=3,rs1=1,rs2=2 → next cycle o_wr_en=1, o_wr_data=0x002081B3, o_wr_addr=0x100.
REQ-029 ADDI rd=1,rs1=0,imm=0xFFFFFFFF, then JAL rd=1,imm=8 → 0xFFF00093 @0x100, then 0x008000EF @0x104; o_count=2.
REQ-030 BEQ with imm=0x00000801 → no write, o_err=1, o_err_opcode=0x63, o_ready=0; i_clear → IDLE, o_err=0.
REQ-031 i_wr_ready=0 for 3 cycles with 2 tuples offered → o_ready=0 while full, word held stable, both written in order at 0x100 and 0x104.
REQ-032 Pointer at 0xFFFFFFFC, two tuples → addresses 0xFFFFFFFC then 0x00000000.
REQ-033 i_rst asserted while o_wr_en=1 and i_wr_ready=0 → o_wr_en=0 immediately, o_count=0, state IDLE.
